// File: rtl/turbosound_multi_pkg.sv
// Shared constants and helpers for the TurboSound multi-PSG block:
// latch decode values, pan field encodings and a ceil-log2 helper.
package turbosound_multi_pkg;

  // Latching SEL_BASE-k selects chip k; CTL_ADDR opens the pan register.
  localparam logic [7:0] SEL_BASE = 8'hFF;
  localparam logic [7:0] CTL_ADDR = 8'hF8;

  typedef enum logic [1:0] {
    PAN_MUTE  = 2'b00,
    PAN_LEFT  = 2'b01,
    PAN_RIGHT = 2'b10,
    PAN_BOTH  = 2'b11
  } pan_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/turbosound_multi_mixer.sv
// Time-multiplexed stereo mixer: one chip per clk7, pan-routed into
// left/right accumulators; sample_stb marks each finished sweep.
module ts_mixer
  import turbosound_multi_pkg::*;
#(
  parameter int NUM_CHIPS = 2,
  parameter int AW        = 9
) (
  input  logic                   clk7,
  input  logic                   reset,
  input  logic [NUM_CHIPS*8-1:0] audio_in,
  input  logic [7:0]             pan,
  output logic [AW-1:0]          audio_l,
  output logic [AW-1:0]          audio_r,
  output logic                   sample_stb
);

  localparam logic [1:0] LAST = 2'(NUM_CHIPS - 1);

  logic [1:0]    idx_q, idx_d;
  logic [AW-1:0] acc_l_q, acc_l_d;
  logic [AW-1:0] acc_r_q, acc_r_d;
  logic [AW-1:0] audio_l_q, audio_l_d;
  logic [AW-1:0] audio_r_q, audio_r_d;
  logic          stb_q, stb_d;

  always_comb begin
    logic [7:0]    cur;
    pan_e          fld;
    logic [AW-1:0] sum_l;
    logic [AW-1:0] sum_r;
    cur = 8'h00;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (idx_q == 2'(k)) cur = audio_in[k*8 +: 8];
    end
    fld   = pan_e'(pan[{idx_q, 1'b0} +: 2]);
    sum_l = acc_l_q;
    sum_r = acc_r_q;
    if (fld == PAN_LEFT || fld == PAN_BOTH)
      sum_l = acc_l_q + AW'(cur);
    if (fld == PAN_RIGHT || fld == PAN_BOTH)
      sum_r = acc_r_q + AW'(cur);
    audio_l_d = audio_l_q;
    audio_r_d = audio_r_q;
    if (idx_q == LAST) begin
      idx_d     = 2'd0;
      acc_l_d   = '0;
      acc_r_d   = '0;
      audio_l_d = sum_l;
      audio_r_d = sum_r;
      stb_d     = 1'b1;
    end else begin
      idx_d   = idx_q + 2'd1;
      acc_l_d = sum_l;
      acc_r_d = sum_r;
      stb_d   = 1'b0;
    end
  end

  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) begin
      idx_q     <= '0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      audio_l_q <= '0;
      audio_r_q <= '0;
      stb_q     <= 1'b0;
    end else begin
      idx_q     <= idx_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      audio_l_q <= audio_l_d;
      audio_r_q <= audio_r_d;
      stb_q     <= stb_d;
    end
  end

  assign audio_l    = audio_l_q;
  assign audio_r    = audio_r_q;
  assign sample_stb = stb_q;

endmodule

// File: rtl/turbosound_multi_ym2149.sv
// Compact YM2149 PSG: 16-register file, address latch, three tone
// channels and a saturating level mix. Bus: BDIR/BC1/BC2 plus A8 chip
// select; ENA clocks the tone counters; RESET_L active low.
module ym2149 (
  input  logic       CLK,
  input  logic       ENA,
  input  logic       RESET_L,
  input  logic       I_A8,
  input  logic       I_BDIR,
  input  logic       I_BC1,
  input  logic       I_BC2,
  input  logic [7:0] I_DA,
  output logic [7:0] O_DA,
  output logic       O_DA_OE_L,
  output logic [7:0] O_AUDIO
);

  logic [7:0]  regs_q [16];
  logic [7:0]  regs_d [16];
  logic [3:0]  addr_q, addr_d;
  logic [11:0] cnt_q [3];
  logic [11:0] cnt_d [3];
  logic [2:0]  tone_q, tone_d;
  logic        act, lat, wr, rd;

  assign act = I_A8 & I_BC2;
  assign lat = act & I_BDIR & I_BC1;
  assign wr  = act & I_BDIR & ~I_BC1;
  assign rd  = act & ~I_BDIR & I_BC1;

  always_comb begin
    logic [11:0] per;
    logic [11:0] per_m1;
    addr_d = addr_q;
    regs_d = regs_q;
    tone_d = tone_q;
    cnt_d  = cnt_q;
    // Addresses with a non-zero high nibble belong to other devices.
    if (lat && I_DA[7:4] == 4'h0) addr_d = I_DA[3:0];
    if (wr) regs_d[addr_q] = I_DA;
    for (int c = 0; c < 3; c++) begin
      per    = {regs_q[2*c+1][3:0], regs_q[2*c]};
      per_m1 = (per == 12'd0) ? 12'd0 : per - 12'd1;
      if (ENA) begin
        if (cnt_q[c] >= per_m1) begin
          cnt_d[c]  = 12'd0;
          tone_d[c] = ~tone_q[c];
        end else begin
          cnt_d[c] = cnt_q[c] + 12'd1;
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_L) begin
    if (!RESET_L) begin
      addr_q <= '0;
      tone_q <= '0;
      regs_q <= '{default: '0};
      cnt_q  <= '{default: '0};
    end else begin
      addr_q <= addr_d;
      tone_q <= tone_d;
      regs_q <= regs_d;
      cnt_q  <= cnt_d;
    end
  end

  always_comb begin
    logic [9:0] mix;
    mix = '0;
    // A channel whose tone is disabled in R7 sits at its level.
    for (int c = 0; c < 3; c++) begin
      if (tone_q[c] | regs_q[7][c])
        mix = mix + {2'b00, regs_q[8+c][3:0], 4'h0};
    end
    O_AUDIO   = (mix[9:8] != 2'b00) ? 8'hFF : mix[7:0];
    O_DA      = regs_q[addr_q];
    O_DA_OE_L = ~rd;
  end

endmodule

// File: rtl/turbosound_multi.sv
// TurboSound: NUM_CHIPS YM2149s on one PSG bus with chip select, a pan
// register and a stereo mixer. Ports: clk7/reset, clken, bdir/bc1/din
// bus in, dout/oe_n read out, audio_l/audio_r with sample_stb.
module turbosound_multi
  import turbosound_multi_pkg::*;
#(
  parameter  int NUM_CHIPS = 2,
  localparam int AW        = 8 + clog2(NUM_CHIPS)
) (
  input  logic          clk7,
  input  logic          reset,
  input  logic          clken,
  input  logic          bdir,
  input  logic          bc1,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          oe_n,
  output logic [AW-1:0] audio_l,
  output logic [AW-1:0] audio_r,
  output logic          sample_stb
);

  logic [1:0]           sel_q, sel_d;
  logic                 ctl_q, ctl_d;
  logic [7:0]           pan_q, pan_d;
  logic                 lat, wr, rd;
  logic                 in_sel, is_ctl, is_addr, sel_ok;
  logic [7:0]           sel_off;
  logic                 hide, chip_bdir, chip_bc1;
  logic [NUM_CHIPS-1:0] a8;
  logic [NUM_CHIPS-1:0] chip_oe_n;
  logic [7:0]           chip_do [NUM_CHIPS];
  logic [NUM_CHIPS*8-1:0] chip_audio;

  assign lat = bdir & bc1;
  assign wr  = bdir & ~bc1;
  assign rd  = ~bdir & bc1;

  assign in_sel  = din[7:2] == SEL_BASE[7:2];
  assign is_ctl  = din == CTL_ADDR;
  assign is_addr = ~in_sel & ~is_ctl;
  assign sel_off = SEL_BASE - din;
  assign sel_ok  = int'(sel_off[1:0]) < NUM_CHIPS;

  always_comb begin
    sel_d = sel_q;
    ctl_d = ctl_q;
    pan_d = pan_q;
    if (lat) begin
      unique case (1'b1)
        in_sel: begin
          if (sel_ok) begin
            sel_d = sel_off[1:0];
            ctl_d = 1'b0;
          end
        end
        is_ctl:  ctl_d = 1'b1;
        is_addr: ctl_d = 1'b0;
      endcase
    end
    if (wr && ctl_q) pan_d = din;
  end

  always_ff @(posedge clk7 or posedge reset) begin
    if (reset) begin
      sel_q <= '0;
      ctl_q <= 1'b0;
      pan_q <= 8'hFF;
    end else begin
      sel_q <= sel_d;
      ctl_q <= ctl_d;
      pan_q <= pan_d;
    end
  end

  // Select/control latches are ours alone; the chips see an idle bus.
  assign hide      = lat & ~is_addr;
  assign chip_bdir = bdir & ~hide;
  assign chip_bc1  = bc1 & ~hide;

  // An address latch also ends control mode, so it must reach the
  // selected chip even though ctl_q only drops on the following edge.
  always_comb begin
    a8 = '0;
    for (int k = 0; k < NUM_CHIPS; k++) begin
      if (sel_q == 2'(k)) a8[k] = ~ctl_q | (lat & is_addr);
    end
  end

  for (genvar k = 0; k < NUM_CHIPS; k++) begin : g_chip
    ym2149 u_ay (
      .CLK       (clk7),
      .ENA       (clken),
      .RESET_L   (~reset),
      .I_A8      (a8[k]),
      .I_BDIR    (chip_bdir),
      .I_BC1     (chip_bc1),
      .I_BC2     (1'b1),
      .I_DA      (din),
      .O_DA      (chip_do[k]),
      .O_DA_OE_L (chip_oe_n[k]),
      .O_AUDIO   (chip_audio[k*8 +: 8])
    );
  end

  always_comb begin
    dout = 8'h00;
    oe_n = 1'b1;
    if (rd) begin
      if (ctl_q) begin
        dout = pan_q;
        oe_n = 1'b0;
      end else begin
        for (int k = 0; k < NUM_CHIPS; k++) begin
          if (sel_q == 2'(k)) begin
            dout = chip_do[k];
            oe_n = chip_oe_n[k];
          end
        end
      end
    end
  end

  ts_mixer #(
    .NUM_CHIPS (NUM_CHIPS),
    .AW        (AW)
  ) u_mix (
    .clk7       (clk7),
    .reset      (reset),
    .audio_in   (chip_audio),
    .pan        (pan_q),
    .audio_l    (audio_l),
    .audio_r    (audio_r),
    .sample_stb (sample_stb)
  );

endmodule

// File: tb/tb_turbosound_multi.sv
// Bench for turbosound_multi: 4-chip and 2-chip instances on a shared
// bus; mixer vectors checked through an expected-sample queue.
module tb_turbosound_multi;

  logic       clk7 = 1'b0;
  logic       reset = 1'b1;
  logic       clken = 1'b0;
  logic       bdir = 1'b0;
  logic       bc1 = 1'b0;
  logic [7:0] din = 8'h00;

  logic [7:0] dout, dout2;
  logic       oe_n, oe_n2;
  logic [9:0] audio_l, audio_r;
  logic [8:0] audio_l2, audio_r2;
  logic       sample_stb, stb2;

  int passed = 0;
  int total = 0;

  logic [19:0] exp_q[$];
  logic [19:0] mon_e;

  always #5 clk7 = ~clk7;

  turbosound_multi #(.NUM_CHIPS(4)) dut (
    .clk7(clk7), .reset(reset), .clken(clken),
    .bdir(bdir), .bc1(bc1), .din(din),
    .dout(dout), .oe_n(oe_n),
    .audio_l(audio_l), .audio_r(audio_r),
    .sample_stb(sample_stb)
  );

  turbosound_multi #(.NUM_CHIPS(2)) dut2 (
    .clk7(clk7), .reset(reset), .clken(clken),
    .bdir(bdir), .bc1(bc1), .din(din),
    .dout(dout2), .oe_n(oe_n2),
    .audio_l(audio_l2), .audio_r(audio_r2),
    .sample_stb(stb2)
  );

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else
      passed++;
  endtask

  task automatic bus(input logic b, input logic c,
                     input logic [7:0] d);
    @(negedge clk7);
    bdir = b; bc1 = c; din = d;
    @(negedge clk7);
    bdir = 1'b0; bc1 = 1'b0; din = 8'h00;
  endtask

  task automatic latch(input logic [7:0] d);
    bus(1'b1, 1'b1, d);
  endtask

  task automatic wr(input logic [7:0] d);
    bus(1'b1, 1'b0, d);
  endtask

  task automatic rd(output logic [7:0] d, output logic o,
                    output logic [7:0] d2, output logic o2);
    @(negedge clk7);
    bdir = 1'b0; bc1 = 1'b1;
    #1;
    d = dout; o = oe_n; d2 = dout2; o2 = oe_n2;
    bc1 = 1'b0;
  endtask

  task automatic first_stb(output int c1, output int c2);
    c1 = 0; c2 = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk7);
      if (c1 == 0 && sample_stb) c1 = i;
      if (c2 == 0 && stb2) c2 = i;
    end
  endtask

  task automatic wait_stb(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk7);
      if (sample_stb) ok = 1'b1;
    end
  endtask

  // Scoreboard side: each finished sample pops one expectation.
  always @(negedge clk7) begin
    if (!reset && sample_stb && exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("mix_l", 32'(audio_l), 32'(mon_e[19:10]));
      check("mix_r", 32'(audio_r), 32'(mon_e[9:0]));
    end
  end

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [7:0]  pan;
    logic [9:0]  el;
    logic [9:0]  er;
  } vec_t;

  vec_t vecs[7];

  task automatic prog(input vec_t v);
    for (int k = 0; k < 4; k++) begin
      latch(8'hFF - 8'(k));
      latch(8'h07); wr(8'h3F);
      latch(8'h08); wr({4'h0, v.va[4*k +: 4]});
      latch(8'h09); wr({4'h0, v.vb[4*k +: 4]});
    end
    latch(8'hF8); wr(v.pan);
    latch(8'h00);
  endtask

  initial begin
    logic [7:0] d, d2;
    logic       o, o2;
    int         c1, c2, gap;
    bit         ok;

    // Chip k level = min(255, 16*(va_k + vb_k)).
    vecs[0] = '{16'h4321, 16'h0000, 8'hE4, 10'h060, 10'h070};
    vecs[1] = '{16'h4321, 16'h0000, 8'hC9, 10'h050, 10'h060};
    vecs[2] = '{16'hFFFF, 16'h1111, 8'hFF, 10'h3FC, 10'h3FC};
    vecs[3] = '{16'hFFFF, 16'h1111, 8'h00, 10'h000, 10'h000};
    vecs[4] = '{16'h000F, 16'h0000, 8'h01, 10'h0F0, 10'h000};
    vecs[5] = '{16'h8000, 16'h0000, 8'h80, 10'h000, 10'h080};
    vecs[6] = '{16'hFFFF, 16'h1111, 8'h5A, 10'h1FE, 10'h1FE};

    repeat (3) @(negedge clk7);
    check("rst_audio_l", 32'(audio_l), 0);
    check("rst_audio_r", 32'(audio_r), 0);
    check("rst_stb", 32'(sample_stb), 0);
    check("rst_stb2", 32'(stb2), 0);
    check("rst_oe_n", 32'(oe_n), 1);
    check("rst_pan", 32'(dut.pan_q), 32'hFF);

    @(negedge clk7);
    reset = 1'b0;
    first_stb(c1, c2);
    check("first_stb_n4", c1, 4);
    check("first_stb_n2", c2, 2);

    latch(8'hFD); latch(8'h07); wr(8'h38);
    for (int k = 0; k < 4; k++) begin
      latch(8'hFF - 8'(k)); latch(8'h07);
      rd(d, o, d2, o2);
      check($sformatf("csel_r7_chip%0d", k), 32'(d),
            (k == 2) ? 32'h38 : 32'h00);
      if (k == 2) check("csel_oe_n", 32'(o), 0);
    end
    @(negedge clk7);
    #1 check("idle_oe_n", 32'(oe_n), 1);

    latch(8'hFE); latch(8'hFC);
    latch(8'h01); wr(8'h5A);
    latch(8'h01);
    rd(d, o, d2, o2);
    check("illegal_sel_keeps1", 32'(d2), 32'h5A);
    latch(8'hFF); latch(8'h01);
    rd(d, o, d2, o2);
    check("illegal_chip0_clean", 32'(d2), 32'h00);

    latch(8'hFD); latch(8'h07);
    latch(8'hF8); wr(8'h1B);
    rd(d, o, d2, o2);
    check("pan_read", 32'(d), 32'h1B);
    check("pan_oe_n", 32'(o), 0);
    latch(8'h00);
    rd(d, o, d2, o2);
    check("ctl_cleared", 32'(d), 32'h00);
    latch(8'h07);
    rd(d, o, d2, o2);
    check("pan_no_ay_write", 32'(d), 32'h38);

    foreach (vecs[i]) begin
      prog(vecs[i]);
      repeat (12) @(negedge clk7);
      exp_q.push_back({vecs[i].el, vecs[i].er});
      for (int t = 0; t < 40 && exp_q.size() != 0; t++)
        @(negedge clk7);
      if (exp_q.size() != 0) begin
        total++;
        $display("FAIL mix_timeout: vec %0d no sample_stb", i);
        exp_q.delete();
      end
    end

    wait_stb(ok);
    gap = 0;
    if (ok) begin
      for (int i = 1; i <= 12 && gap == 0; i++) begin
        @(negedge clk7);
        if (sample_stb) gap = i;
      end
    end
    check("stb_period", gap, 4);

    wait_stb(ok);
    @(negedge clk7);
    @(negedge clk7);
    check("mid_idx", 32'(dut.u_mix.idx_q), 2);
    reset = 1'b1;
    #1;
    check("mid_audio_l", 32'(audio_l), 0);
    check("mid_audio_r", 32'(audio_r), 0);
    check("mid_stb", 32'(sample_stb), 0);
    check("mid_pan", 32'(dut.pan_q), 32'hFF);
    check("mid_acc_l", 32'(dut.u_mix.acc_l_q), 0);
    @(negedge clk7);
    reset = 1'b0;
    first_stb(c1, c2);
    check("rel_stb_n4", c1, 4);
    check("rel_stb_n2", c2, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
